// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch -> instruction buffer -> dispatch interface.
// Holds the packet layouts and the default buffer depth.
package inst_buffer_pkg;

  localparam int XLEN             = 32;
  localparam int IB_DEPTH_DEFAULT = 8;

  // Fetch-side packet as produced by the fetch stage.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } if_ib_packet_t;

  // Dispatch-side view of the oldest buffered instruction.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_npc;
    logic            pred_taken;
    logic            valid;
  } ib_dp_packet_t;

  // Stored entry: the dispatch packet minus valid, which is implied by occupancy.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_npc;
    logic            pred_taken;
  } ib_entry_t;

  function automatic ib_entry_t make_entry(input if_ib_packet_t pkt,
                                           input logic          taken,
                                           input logic [XLEN-1:0] npc);
    ib_entry_t e;
    e.inst       = pkt.inst;
    e.pc         = pkt.pc;
    e.pred_npc   = npc;
    e.pred_taken = taken;
    return e;
  endfunction

  function automatic ib_dp_packet_t to_dp_packet(input ib_entry_t e, input logic valid);
    ib_dp_packet_t p;
    p.inst       = e.inst;
    p.pc         = e.pc;
    p.pred_npc   = e.pred_npc;
    p.pred_taken = e.pred_taken;
    p.valid      = valid;
    return p;
  endfunction

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: circular FIFO with wrap-bit pointers,
// first-word-fall-through head, full back-pressure and single-cycle squash.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter  int IB_DEPTH = IB_DEPTH_DEFAULT,
  localparam int CNT_W    = $clog2(IB_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  if_ib_packet_t     if_ib_packet,
  input  logic              bp_taken,
  input  logic [XLEN-1:0]   bp_npc,
  input  logic              squash,
  input  logic              dp_ready,
  output ib_dp_packet_t     ib_dp_packet,
  output logic              ib_full,
  output logic              ib_empty,
  output logic [CNT_W-1:0]  ib_count
);

  localparam int IDX_W = CNT_W - 1;

  ib_entry_t        entries_q [IB_DEPTH];
  ib_entry_t        wr_entry;
  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             enq, deq, wr_en;

  // The fetch-side NPC is superseded by the predictor's bp_npc.
  logic unused_fetch_npc;
  assign unused_fetch_npc = ^if_ib_packet.npc;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Status is decoded from registered pointers only, so a dequeue never frees a slot
  // for an enqueue in the same cycle.
  assign ib_empty = (head_q == tail_q);
  assign ib_full  = (head_idx == tail_idx) && (head_q[CNT_W-1] != tail_q[CNT_W-1]);
  assign ib_count = tail_q - head_q;

  assign enq   = if_ib_packet.valid && !ib_full;
  assign deq   = dp_ready && !ib_empty;
  assign wr_en = enq && !squash;

  always_comb begin
    wr_entry = make_entry(if_ib_packet, bp_taken, bp_npc);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (squash) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (deq) head_d = head_q + CNT_W'(1);
      if (enq) tail_d = tail_q + CNT_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until the pointers
  // cover them, and leaving reset off lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) entries_q[tail_idx] <= wr_entry;
  end

  always_comb begin
    ib_dp_packet = to_dp_packet(entries_q[head_idx], !ib_empty);
  end

  a_full_matches_count : assert property (@(posedge clock) disable iff (reset)
    ib_full == (ib_count == CNT_W'(IB_DEPTH)));
  a_empty_matches_count : assert property (@(posedge clock) disable iff (reset)
    ib_empty == (ib_count == '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  if_ib_packet_t   if_ib_packet;
  logic            bp_taken;
  logic [XLEN-1:0] bp_npc;
  logic            squash;
  logic            dp_ready;
  ib_dp_packet_t   ib_dp_packet;
  logic            ib_full;
  logic            ib_empty;
  logic [CW-1:0]   ib_count;

  inst_buffer #(.IB_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_ib_packet (if_ib_packet),
    .bp_taken     (bp_taken),
    .bp_npc       (bp_npc),
    .squash       (squash),
    .dp_ready     (dp_ready),
    .ib_dp_packet (ib_dp_packet),
    .ib_full      (ib_full),
    .ib_empty     (ib_empty),
    .ib_count     (ib_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        taken;
  } exp_t;

  exp_t model_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of at most DEPTH entries.
  always @(posedge clock or posedge reset) begin
    if (reset || squash) begin
      model_q.delete();
    end else begin : model_step
      int sz;
      sz = model_q.size();
      if (dp_ready && sz > 0) void'(model_q.pop_front());
      if (if_ib_packet.valid && sz < DEPTH)
        model_q.push_back('{pc: if_ib_packet.pc, inst: if_ib_packet.inst,
                            npc: bp_npc, taken: bp_taken});
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    check("count", 64'(ib_count), 64'(model_q.size()));
    check("empty", 64'(ib_empty), 64'(model_q.size() == 0));
    check("full",  64'(ib_full),  64'(model_q.size() == DEPTH));
    check("valid", 64'(ib_dp_packet.valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("head_pc",    64'(ib_dp_packet.pc),         64'(model_q[0].pc));
      check("head_inst",  64'(ib_dp_packet.inst),       64'(model_q[0].inst));
      check("head_npc",   64'(ib_dp_packet.pred_npc),   64'(model_q[0].npc));
      check("head_taken", 64'(ib_dp_packet.pred_taken), 64'(model_q[0].taken));
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                      input logic [31:0] npc, input logic rdy, input logic sq);
    if_ib_packet.valid = v;
    if_ib_packet.pc    = pc;
    if_ib_packet.inst  = inst_of(pc);
    if_ib_packet.npc   = pc + 32'd4;
    bp_taken           = tk;
    bp_npc             = npc;
    dp_ready           = rdy;
    squash             = sq;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, pc + 32'd4, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_empty"}, 64'(ib_empty), 64'd1);
    check({tag, "_full"},  64'(ib_full),  64'd0);
    check({tag, "_count"}, 64'(ib_count), 64'd0);
    check({tag, "_valid"}, 64'(ib_dp_packet.valid), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    if_ib_packet = '0;
    bp_taken     = 1'b0;
    bp_npc       = '0;
    squash       = 1'b0;
    dp_ready     = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      idle();
      check_empty("t1");
    end

    // 2: three enqueues, no dispatch
    push(32'h100);
    check("t2_valid_after1", 64'(ib_dp_packet.valid), 64'd1);
    push(32'h104);
    push(32'h108);
    check("t2_count", 64'(ib_count), 64'd3);
    check("t2_pc",    64'(ib_dp_packet.pc), 64'h100);
    check("t2_npc",   64'(ib_dp_packet.pred_npc), 64'h104);
    for (int i = 0; i < 3; i++) pop();
    check_empty("t2_drain");

    // 3: fill with nine, ninth dropped, then drain in order
    for (int i = 0; i < 9; i++) begin
      push(32'h300 + 32'(4 * i));
      if (i == 6) check("t3_notfull_7", 64'(ib_full), 64'd0);
      if (i == 7) begin
        check("t3_full_8",  64'(ib_full),  64'd1);
        check("t3_count_8", 64'(ib_count), 64'd8);
      end
    end
    check("t3_count_9", 64'(ib_count), 64'd8);
    check("t3_head_9",  64'(ib_dp_packet.pc), 64'h300);
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_pc", 64'(ib_dp_packet.pc), 64'(32'h300 + 32'(4 * i)));
      pop();
    end
    check_empty("t3_end");

    // 4: steady stream at occupancy 4, pointers wrap
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i));
    for (int i = 0; i < 20; i++) begin
      check("t4_pc", 64'(ib_dp_packet.pc), 64'(32'h400 + 32'(4 * i)));
      step(1'b1, 32'h410 + 32'(4 * i), 1'b0, 32'h414 + 32'(4 * i), 1'b1, 1'b0);
      check("t4_count", 64'(ib_count), 64'd4);
    end
    for (int i = 0; i < 4; i++) begin
      check("t4_tail_pc", 64'(ib_dp_packet.pc), 64'(32'h450 + 32'(4 * i)));
      pop();
    end
    check_empty("t4_end");

    // 5: predicted-taken branch entry
    step(1'b1, 32'h200, 1'b1, 32'h1F0, 1'b0, 1'b0);
    check("t5_pc",    64'(ib_dp_packet.pc), 64'h200);
    check("t5_taken", 64'(ib_dp_packet.pred_taken), 64'd1);
    check("t5_npc",   64'(ib_dp_packet.pred_npc), 64'h1F0);
    pop();

    // 6: squash beats concurrent enqueue and dispatch
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i));
    check("t6_count5", 64'(ib_count), 64'd5);
    step(1'b1, 32'h600, 1'b0, 32'h604, 1'b1, 1'b1);
    check_empty("t6_squash");
    idle();
    check_empty("t6_after");

    // 6b: asynchronous reset mid-fill clears before the next edge
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(4 * i));
    check("t6b_count3", 64'(ib_count), 64'd3);
    #3 reset = 1'b1;
    #1 check_empty("t6b_async");
    @(negedge clock);
    reset = 1'b0;
    idle();
    check_empty("t6b_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
